pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the IF/ID stall and flush inputs, the PC write enable, the ID/EX bubble insert, and a global freeze for the later stages. It resolves four sources in fixed priority: post-reset initialisation, data-memory busy, load-use hazard, and taken branch/jump. It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

## Interface
- INIT_CYCLES, default 4: cycles of forced flush/bubble after reset release (≥1).
- MEM_TIMEOUT, default 255: consecutive freeze cycles before mem_timeout_o sets (1..65535).
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- id_rs_i  in  5  rs of the instruction in ID.
- id_rt_i  in  5  rt of the instruction in ID.
- id_uses_rt_i  in  1  the ID instruction reads rt.
- ex_memread_i  in  1  the instruction in EX is a load.
- ex_rt_i  in  5  destination register of the EX load.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- jump_i  in  1  jump in ID this cycle.
- mem_busy_i  in  1  data memory cannot complete this cycle.
- pc_write_o  out  1  PC update enable.
- hazard_IF_ID_o  out  1  hold IF/ID (stall).
- flush_IF_ID_o  out  1  clear IF/ID.
- bubble_ID_EX_o  out  1  zero the ID/EX control fields.
- freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  16  saturating count of stall cycles.
- flush_cnt_o  out  16  saturating count of flush cycles.
- mem_timeout_o  out  1  sticky memory-timeout flag.

## Operation
- FSM states: INIT, RUN, MEM_WAIT. Reset state is INIT.
- INIT:
  - Outputs: pc_write_o=0, flush_IF_ID_o=1, bubble_ID_EX_o=1, hazard_IF_ID_o=0, freeze_o=0.
  - All hazard inputs are ignored.
  - init_cnt starts at 0 and increments each edge. The edge where init_cnt==INIT_CYCLES-1 moves to RUN.
- load_use = ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)).
- RUN and MEM_WAIT resolve outputs combinationally from the current cycle's inputs, in priority order:
  - mem_busy_i=1 (freeze): freeze_o=1, hazard_IF_ID_o=1, pc_write_o=0, bubble=0, flush=0. Next state is MEM_WAIT.
  - else load_use (stall): hazard_IF_ID_o=1, pc_write_o=0, bubble_ID_EX_o=1, flush=0. Next state is RUN.
  - else branch_taken_i|jump_i (flush): flush_IF_ID_o=1, pc_write_o=1, others 0.
  - else: pc_write_o=1, all others 0.
- MEM_WAIT with mem_busy_i=0: freeze releases in that same cycle and the remaining priorities apply. Next state is RUN.
- A deferred branch under stall or freeze is not remembered. ID re-presents it on release.
- wait_cnt (16 bits, saturating):
  - Increments on every edge of a freeze cycle.
  - Clears on every non-freeze edge.
  - When a freeze cycle begins with wait_cnt==MEM_TIMEOUT-1, mem_timeout_o=1 from the next cycle.
  - mem_timeout_o stays set until rst_n_i. Freeze itself is never forced off.
- stall_cnt_o: +1 at each edge outside INIT where pc_write_o=0. Saturates at 0xFFFF.
- flush_cnt_o: +1 at each edge in RUN/MEM_WAIT where flush_IF_ID_o=1. INIT flushes are not counted. Saturates at 0xFFFF.

## Timing
- rst_n_i low forces the following immediately, with no clock needed:
  - state=INIT, init_cnt=0, wait_cnt=0, counters=0, mem_timeout_o=0.
  - Outputs: pc_write_o=0, flush_IF_ID_o=1, bubble_ID_EX_o=1, hazard_IF_ID_o=0, freeze_o=0.
- Cycle 0 is the first cycle after rst_n_i rises. INIT outputs hold in cycles 0..INIT_CYCLES-1. RUN begins in cycle INIT_CYCLES.
- Stall, flush and freeze outputs have zero latency (same cycle as the inputs). FSM, counters and flag are registered (one edge).
- Reset asserted mid-MEM_WAIT or mid-stall aborts with no residual state. The pipeline restarts through INIT.
- Counters never wrap. Width is exactly 16 bits.

## Test plan
- Reset release, INIT_CYCLES=4:
  - Cycles 0–3: flush=1, bubble=1, pc_write=0.
  - Cycle 4 with no hazards: pc_write=1, flush=0.
  - flush_cnt_o=0, stall_cnt_o=0.
- Load-use:
  - ex_memread=1, ex_rt=5, id_rs=5 → same cycle pc_write=0, hazard=1, bubble=1; stall_cnt +1.
  - ex_rt=0 → no stall.
  - id_rt=5 with id_uses_rt=0 → no stall.
- Branch:
  - branch_taken=1 alone → flush=1, pc_write=1; flush_cnt +1.
  - Same with load-use → flush=0, stall asserted, flush_cnt unchanged.
- Memory busy:
  - mem_busy=1 for 3 cycles, with load-use also true → freeze=1, hazard=1, bubble=0 for 3 cycles; stall_cnt +3.
  - Cycle 4: freeze=0, state back to RUN.
- Timeout, MEM_TIMEOUT=8, mem_busy held 10 cycles:
  - mem_timeout_o rises in freeze cycle 9.
  - It stays 1 after busy drops and clears only on rst_n_i low.
- Async reset mid-MEM_WAIT: drop rst_n_i between clock edges → outputs, counters and flag reach their reset values before the next edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: post-reset init flush, memory freeze,
// load-use stall and branch/jump flush, with saturating statistics and a sticky timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        mem_busy_i,
  output logic        pc_write_o,
  output logic        hazard_IF_ID_o,
  output logic        flush_IF_ID_o,
  output logic        bubble_ID_EX_o,
  output logic        freeze_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
  output logic        mem_timeout_o
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [15:0]   WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_MEM_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic [15:0]   flush_cnt_q, flush_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;
  logic          load_use;

  assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  // Outputs are decoded from the current state and inputs so stalls, flushes and
  // freezes take effect in the same cycle; only bookkeeping is registered.
  always_comb begin
    pc_write_o     = 1'b0;
    hazard_IF_ID_o = 1'b0;
    flush_IF_ID_o  = 1'b0;
    bubble_ID_EX_o = 1'b0;
    freeze_o       = 1'b0;
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    wait_cnt_d     = '0;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    mem_timeout_d  = mem_timeout_q;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy_i) begin
          freeze_o       = 1'b1;
          hazard_IF_ID_o = 1'b1;
          state_d        = ST_MEM_WAIT;
        end else if (load_use) begin
          hazard_IF_ID_o = 1'b1;
          bubble_ID_EX_o = 1'b1;
          state_d        = ST_RUN;
        end else if (branch_taken_i || jump_i) begin
          flush_IF_ID_o  = 1'b1;
          pc_write_o     = 1'b1;
          state_d        = ST_RUN;
        end else begin
          pc_write_o     = 1'b1;
          state_d        = ST_RUN;
        end

        if (freeze_o) begin
          if (wait_cnt_q == WAIT_LAST) mem_timeout_d = 1'b1;
          wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
        end
        if (!pc_write_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_IF_ID_o && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
      end
      default: begin
        flush_IF_ID_o  = 1'b1;
        bubble_ID_EX_o = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          state_d    = ST_INIT;
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign mem_timeout_o = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned INIT_N = 4;
  localparam int unsigned TMO_N  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, ex_memread = 1'b0, br = 1'b0, jmp = 1'b0, busy = 1'b0;
  logic        pc_write, hazard, flush, bubble, freeze, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: cycles of INIT remaining, statistics, consecutive freeze length.
  int unsigned m_init_left;
  int unsigned m_stalls, m_flushes, m_run;
  bit          m_tmo;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_N), .MEM_TIMEOUT(TMO_N)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
    .branch_taken_i(br), .jump_i(jmp), .mem_busy_i(busy),
    .pc_write_o(pc_write), .hazard_IF_ID_o(hazard), .flush_IF_ID_o(flush),
    .bubble_ID_EX_o(bubble), .freeze_o(freeze),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_timeout_o(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control vector {pc_write, hazard, flush, bubble, freeze}.
  function automatic logic [4:0] exp_ctl();
    bit lu;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (m_init_left > 0) return 5'b00110;
    if (busy)            return 5'b01001;
    if (lu)              return 5'b01010;
    if (br || jmp)       return 5'b10100;
    return 5'b10000;
  endfunction

  task automatic model_reset();
    m_init_left = INIT_N;
    m_stalls = 0; m_flushes = 0; m_run = 0; m_tmo = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ctl"},   {27'd0, pc_write, hazard, flush, bubble, freeze}, {27'd0, exp_ctl()});
    check({tag, ".stall"}, {16'd0, stall_cnt}, m_stalls);
    check({tag, ".flush"}, {16'd0, flush_cnt}, m_flushes);
    check({tag, ".tmo"},   {31'd0, mem_timeout}, {31'd0, m_tmo});
  endtask

  // Entered just after a rising edge; inputs already driven.
  task automatic step(input string tag);
    logic [4:0] e;
    @(negedge clk);
    check_all(tag);
    e = exp_ctl();
    @(posedge clk);
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (!e[4] && m_stalls < 16'hFFFF) m_stalls++;
      if (e[2] && m_flushes < 16'hFFFF) m_flushes++;
      if (e[0]) begin
        if (m_run < 16'hFFFF) m_run++;
        if (m_run >= TMO_N) m_tmo = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] xrt, input logic b,
                        input logic j, input logic mb);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr;
    ex_rt = xrt; br = b; jmp = j; busy = mb;
  endtask

  // Asserts reset between edges and checks the reset values before any edge arrives.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    @(posedge clk);
    #1 rst_n = 1'b1;

    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < INIT_N; i++) step("init");
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("run_idle");

    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);  step("lu_rs");
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);  step("lu_r0");
    set_in(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);  step("lu_no_rt");
    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);  step("lu_rt");
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);  step("branch");
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);  step("jump");
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);  step("br_lu");
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("busy3");
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);  step("busy_rel");
    step("busy_after");

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step("tmo_busy");
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("tmo_sticky");

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("pre_rst_busy");
    do_reset("rst_memwait");
    for (int i = 0; i < INIT_N + 2; i++) step("post_rst");

    for (int i = 0; i < 3000; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0));
      if ((i % 200) == 100) busy = 1'b1;
      step("rand");
      if ($urandom_range(0, 499) == 0) do_reset("rand_rst");
    end
    // Long busy burst so the timeout fires again after the random phase.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step("tail_busy");
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("tail_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
